// File: rtl/reg_4bit.sv
// rtl/reg_4bit.sv - WIDTH-bit D register with synchronous active-low reset
// Pure holding stage: q is driven straight from flops, no enable, no input-to-output path.
module reg_4bit #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Reset wins over data in any cycle where rst is sampled low.
   always_comb begin
      q_d = d;
      if (!rst) begin
         q_d = RST_VAL;
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: tb/tb_reg_4bit.sv
// tb/tb_reg_4bit.sv - directed self-checking bench for reg_4bit
// Inputs change on the falling edge; q is sampled 1 ns after the rising edge.
module tb_reg_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] d;
   logic [3:0] q;

   int errors;
   int checks;

   reg_4bit #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [3:0] v);
      @(negedge clk);
      rst = r;
      d   = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 4'b1111);
      checks++;
      if (q !== 4'b0000) begin
         errors++;
         $display("FAIL reset_first got=%b exp=%b", q, 4'b0000);
      end
      step(1'b0, 4'b1010);
      checks++;
      if (q !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold got=%b exp=%b", q, 4'b0000);
      end
   endtask

   task automatic test_load();
      step(1'b1, 4'b1010);
      checks++;
      if (q !== 4'b1010) begin
         errors++;
         $display("FAIL load_1010 got=%b exp=%b", q, 4'b1010);
      end
      step(1'b1, 4'b0101);
      checks++;
      if (q !== 4'b0101) begin
         errors++;
         $display("FAIL load_0101 got=%b exp=%b", q, 4'b0101);
      end
   endtask

   task automatic test_hold();
      step(1'b1, 4'b0011);
      checks++;
      if (q !== 4'b0011) begin
         errors++;
         $display("FAIL hold_load got=%b exp=%b", q, 4'b0011);
      end
      @(negedge clk);
      d = 4'b1100;
      #2;
      checks++;
      if (q !== 4'b0011) begin
         errors++;
         $display("FAIL hold_mid got=%b exp=%b", q, 4'b0011);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q !== 4'b1100) begin
         errors++;
         $display("FAIL hold_next got=%b exp=%b", q, 4'b1100);
      end
   endtask

   task automatic test_sync_reset();
      step(1'b1, 4'b1001);
      checks++;
      if (q !== 4'b1001) begin
         errors++;
         $display("FAIL sync_load got=%b exp=%b", q, 4'b1001);
      end
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (q !== 4'b1001) begin
         errors++;
         $display("FAIL sync_pulse_mid got=%b exp=%b", q, 4'b1001);
      end
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (q !== 4'b1001) begin
         errors++;
         $display("FAIL sync_pulse_edge got=%b exp=%b", q, 4'b1001);
      end
      step(1'b0, 4'b1001);
      checks++;
      if (q !== 4'b0000) begin
         errors++;
         $display("FAIL sync_edge_reset got=%b exp=%b", q, 4'b0000);
      end
   endtask

   task automatic test_release();
      step(1'b1, 4'b1111);
      step(1'b0, 4'b0110);
      checks++;
      if (q !== 4'b0000) begin
         errors++;
         $display("FAIL release_c0 got=%b exp=%b", q, 4'b0000);
      end
      step(1'b0, 4'b0110);
      checks++;
      if (q !== 4'b0000) begin
         errors++;
         $display("FAIL release_c1 got=%b exp=%b", q, 4'b0000);
      end
      step(1'b1, 4'b0110);
      checks++;
      if (q !== 4'b0110) begin
         errors++;
         $display("FAIL release_load got=%b exp=%b", q, 4'b0110);
      end
   endtask

   task automatic test_back_to_back();
      logic       tv_r [20];
      logic [3:0] tv_d [20];
      logic [3:0] tv_e [20];
      tv_r = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tv_d = '{4'h3, 4'h7, 4'h9, 4'hF, 4'h4, 4'hE, 4'h1, 4'h8, 4'h0, 4'hC,
               4'h5, 4'hB, 4'h2, 4'h6, 4'hA, 4'hD, 4'h6, 4'hF, 4'h8, 4'h7};
      tv_e = '{4'h3, 4'h0, 4'h9, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hC,
               4'h5, 4'h0, 4'h2, 4'h0, 4'h0, 4'hD, 4'h6, 4'h0, 4'h8, 4'h7};
      for (int i = 0; i < 20; i++) begin
         step(tv_r[i], tv_d[i]);
         checks++;
         if (q !== tv_e[i]) begin
            errors++;
            $display("FAIL b2b_%0d got=%h exp=%h", i, q, tv_e[i]);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      d      = 4'b0000;
      test_reset();
      test_load();
      test_hold();
      test_sync_reset();
      test_release();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_4bit.md
# reg_4bit

- 4-bit D-type storage register with synchronous, active-low reset.
- Samples the 4-bit data input on every rising clock edge and presents it on the output until the next edge.
- Used as a pipeline/holding stage inside a single clock domain.
- No enable, no combinational path from input to output.

## Interface
Parameters:
- WIDTH, 4, data width in bits; all behaviour below is stated for the default and scales bitwise.
- RST_VAL, 4'b0000, value loaded into q on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, active-low; one clock; reset is synchronous and active-low.
- d    input  4  data to be captured.
- q    output 4  registered data, driven directly from flops.

## Operation
- At each rising edge of clk:
  - if rst == 0: q <= RST_VAL (4'b0000);
  - else: q <= d.
- Between edges q holds its value regardless of activity on d or rst.
- Reset has priority over data; d is ignored in any cycle where rst is sampled low.
- Reset is synchronous only:
  - asserting or deasserting rst between edges has no effect on q until the next rising edge;
  - there is no asynchronous clear path.
- Every bit is independent; no arithmetic, saturation or wrap-around.
- Power-up value of q before the first rising edge is undefined (X in simulation).
  - A bench must apply either a reset edge or a data edge before checking q.
- X/Z on d with rst high propagates into q at the edge.
- X on rst at an edge: q is undefined for that cycle; benches must not rely on it.

## Timing
- Latency: 1 clock. A value on d that is stable at rising edge N appears on q after edge N, within clk-to-q.
  - It remains until edge N+1.
- Reset latency: 1 clock.
  - rst low at edge N gives q == 4'b0000 after edge N.
  - rst high at edge N+1 loads d at that edge.
- Inputs must meet setup/hold about the rising edge.
  - Bench convention: drive d and rst on the falling edge.
  - Check q about 1 ns after the following rising edge.
- Back-to-back loads are allowed every cycle; throughput is one word per clock.
- Simultaneous change of d and rst in the same cycle: reset wins.

## Test plan
- Reset: rst=0, d=4'b1111 at an edge -> q=4'b0000 after that edge; hold rst=0 with d=4'b1010 -> q stays 4'b0000.
- Load: rst=1, d=4'b1010 at an edge -> q=4'b1010; next edge with d=4'b0101 -> q=4'b0101.
- Hold between edges: after q=4'b0011, toggle d to 4'b1100 mid-cycle -> q still 4'b0011 until the next rising edge, then 4'b1100.
- Synchronous reset check:
  - with q=4'b1001, pulse rst low between edges and return it high before the next edge -> q unchanged (4'b1001);
  - rst low at an edge -> 4'b0000.
- Reset release: rst=0 for 2 cycles, then rst=1 with d=4'b0110 -> q=4'b0000, 4'b0000, then 4'b0110 at the release edge.
- Randomized: 20 cycles with random d and ~50% random rst (driven on the falling edge) -> after each rising edge, q == (rst ? d : 4'b0000) with rst active-low semantics; zero mismatches required.
